// File: rtl/weight_mem_arbiter_if.sv
// Bundle between the config/hash requesters and the arbiter, including the
// weight SRAM pins the arbiter drives.
interface weight_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              cfg_wr_valid;
  logic [ADDR_W-1:0] cfg_wr_addr;
  logic [DATA_W-1:0] cfg_wr_data;
  logic              cfg_wr_ready;
  logic              comp_rd_req;
  logic [ADDR_W-1:0] comp_rd_addr;
  logic              comp_rd_grant;
  logic              comp_rd_valid;
  logic              w_mem_cen;
  logic              w_mem_wen;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              buf_empty;

  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, comp_rd_req, comp_rd_addr,
    input  cfg_wr_ready, comp_rd_grant, comp_rd_valid,
    input  w_mem_cen, w_mem_wen, w_mem_addr, w_mem_wdata, buf_empty
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, comp_rd_req, comp_rd_addr,
    output cfg_wr_ready, comp_rd_grant, comp_rd_valid,
    output w_mem_cen, w_mem_wen, w_mem_addr, w_mem_wdata, buf_empty
  );
endinterface

// File: rtl/weight_mem_arbiter.sv
// Single-port weight SRAM arbiter: buffers config writes in a FIFO and shares
// the SRAM with compute reads, with write anti-starvation and RAW protection.
module weight_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  weight_mem_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [ADDR_W-1:0] buf_addr [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic              vld_p1;

  logic full;
  logic pend;
  logic haz;
  logic force_wr;
  logic push;
  logic do_wr;
  logic do_rd;

  assign full     = (count == CNT_FULL);
  assign pend     = (count != '0);
  assign force_wr = pend && (starve_cnt == STV_LAST);

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    haz = 1'b0;
    off = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (bus.comp_rd_req && (CNT_W'(off) < count) && (buf_addr[i] == bus.comp_rd_addr))
        haz = 1'b1;
    end
  end

  assign do_wr = !rst && pend && (!bus.comp_rd_req || haz || force_wr);
  assign do_rd = !rst && !do_wr && bus.comp_rd_req;
  assign push  = !rst && bus.cfg_wr_valid && !full;

  // Stage p0: SRAM command driven combinationally from the decision.
  assign bus.w_mem_cen     = !(do_wr || do_rd);
  assign bus.w_mem_wen     = !do_wr;
  assign bus.w_mem_addr    = rst   ? '0 :
                             do_wr ? buf_addr[rd_ptr] :
                             do_rd ? bus.comp_rd_addr : addr_hold;
  assign bus.w_mem_wdata   = rst   ? '0 :
                             do_wr ? buf_data[rd_ptr] : wdata_hold;
  assign bus.comp_rd_grant = do_rd;
  assign bus.comp_rd_valid = vld_p1;
  assign bus.cfg_wr_ready  = !full;
  assign bus.buf_empty     = !pend;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= bus.cfg_wr_addr;
      buf_data[wr_ptr] <= bus.cfg_wr_data;
    end
  end

  // Stage p1: control state and read-valid, aligned with SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= do_rd;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_wr)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_wr);
      if (!pend || do_wr)
        starve_cnt <= '0;
      else if (do_rd && (starve_cnt != STV_LAST))
        starve_cnt <= starve_cnt + 1'b1;
      if (do_wr) begin
        addr_hold  <= buf_addr[rd_ptr];
        wdata_hold <= buf_data[rd_ptr];
      end else if (do_rd) begin
        addr_hold <= bus.comp_rd_addr;
      end
    end
  end
endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Bench for weight_mem_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based reference model and an SRAM model.
module tb_weight_mem_arbiter;
  localparam int ADDR_W = 10, DATA_W = 16, BUF_DEPTH = 4, STARVE_MAX = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  weight_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] sram_q;
  always @(posedge clk) begin
    if (!bus.w_mem_cen) begin
      if (!bus.w_mem_wen) sram[bus.w_mem_addr] <= bus.w_mem_wdata;
      else                sram_q <= sram[bus.w_mem_addr];
    end
  end

  ent_t              q[$];
  int                starve;
  bit                prev_grant;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;
  logic [DATA_W-1:0] exp_mem [int];
  bit                rd_chk;
  logic [DATA_W-1:0] rd_exp;
  bit                last_dr, last_rst;
  int                n_cmp = 0, n_err = 0;

  logic              obs_cen, obs_wen, obs_grant, obs_rdv, obs_ready, obs_empty;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_wdata, obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare the DUT against the model mid-cycle, then advance the model.
  task automatic cyc();
    bit w, haz, frc, dw, dr, push;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    ent_t e;
    @(negedge clk);
    obs_cen = bus.w_mem_cen;   obs_wen = bus.w_mem_wen;   obs_grant = bus.comp_rd_grant;
    obs_rdv = bus.comp_rd_valid; obs_ready = bus.cfg_wr_ready; obs_empty = bus.buf_empty;
    obs_addr = bus.w_mem_addr; obs_wdata = bus.w_mem_wdata; obs_rdata = sram_q;
    w = (q.size() > 0);
    haz = 1'b0;
    foreach (q[i]) if (bus.comp_rd_req && q[i].a == bus.comp_rd_addr) haz = 1'b1;
    frc = w && (starve == STARVE_MAX - 1);
    dw = !rst && w && (!bus.comp_rd_req || haz || frc);
    dr = !rst && !dw && bus.comp_rd_req;
    ea = rst ? '0 : dw ? q[0].a : dr ? bus.comp_rd_addr : last_a;
    ed = rst ? '0 : dw ? q[0].d : last_d;
    chk("rd_valid", obs_rdv, prev_grant);
    if (prev_grant && rd_chk) chk("rd_data", obs_rdata, rd_exp);
    chk("grant", obs_grant, dr);
    chk("cen", obs_cen, !(dw || dr));
    chk("wen", obs_wen, !dw);
    chk("addr", obs_addr, ea);
    if (dw || !obs_cen || rst) chk("wdata", obs_wdata, ed);
    if (!rst) begin
      chk("ready", obs_ready, q.size() < BUF_DEPTH);
      chk("buf_empty", obs_empty, q.size() == 0);
    end
    push = !rst && bus.cfg_wr_valid && (q.size() < BUF_DEPTH);
    if (rst) begin
      q.delete(); starve = 0; prev_grant = 0; last_a = '0; last_d = '0; rd_chk = 0;
    end else begin
      prev_grant = dr;
      rd_chk = dr && exp_mem.exists(int'(bus.comp_rd_addr));
      if (rd_chk) rd_exp = exp_mem[int'(bus.comp_rd_addr)];
      if (dw) begin
        e = q.pop_front();
        exp_mem[int'(e.a)] = e.d;
        last_a = e.a; last_d = e.d;
      end else if (dr) begin
        last_a = bus.comp_rd_addr;
      end
      if (push) q.push_back(ent_t'{a: bus.cfg_wr_addr, d: bus.cfg_wr_data});
      if (!w || dw) starve = 0;
      else if (dr && starve < STARVE_MAX - 1) starve++;
    end
    last_dr = dr; last_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic r, input logic [ADDR_W-1:0] ra);
    bus.cfg_wr_valid = v; bus.cfg_wr_addr = wa; bus.cfg_wr_data = wd;
    bus.comp_rd_req = r;  bus.comp_rd_addr = ra;
  endtask

  initial begin
    int waited, wen_seen;
    bit hold;
    drive(1'b0, '0, '0, 1'b0, '0);
    starve = 0; prev_grant = 0; last_a = '0; last_d = '0; rd_chk = 0;
    last_dr = 0; last_rst = 1;

    // Reset with random inputs for two cycles.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 1'($urandom), ADDR_W'($urandom));
      cyc();
    end
    chk("rst_cen", obs_cen, 1'b1);
    chk("rst_grant", obs_grant, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    cyc();
    chk("post_rst_ready", obs_ready, 1'b1);
    chk("post_rst_empty", obs_empty, 1'b1);
    chk("post_rst_rdv", obs_rdv, 1'b0);

    // Write burst, no reads.
    drive(1'b1, 10'h010, 16'h00AA, 1'b0, '0); cyc();
    chk("burst_c0_wen", obs_wen, 1'b1);
    drive(1'b1, 10'h011, 16'h00BB, 1'b0, '0); cyc();
    chk("burst_c1_addr", {obs_wen, obs_addr}, {1'b0, 10'h010});
    drive(1'b1, 10'h012, 16'h00CC, 1'b0, '0); cyc();
    chk("burst_c2_addr", {obs_wen, obs_addr}, {1'b0, 10'h011});
    drive(1'b0, '0, '0, 1'b0, '0); cyc();
    chk("burst_c3_addr", {obs_wen, obs_addr, obs_wdata}, {1'b0, 10'h012, 16'h00CC});
    cyc();
    chk("burst_c4_empty", obs_empty, 1'b1);

    // Starvation: continuous reads, one write at cycle 0.
    drive(1'b1, 10'h020, 16'h5555, 1'b1, 10'h3FF); cyc();
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("starve_rd_c%0d", k), {obs_grant, obs_wen}, 2'b11);
    end
    cyc();
    chk("starve_force_c8", {obs_grant, obs_wen, obs_addr}, {2'b00, 10'h020});
    cyc();
    chk("starve_resume_c9", obs_grant, 1'b1);

    // RAW hazard: two buffered writes to 0x005, then a read of 0x005.
    drive(1'b1, 10'h005, 16'h1111, 1'b1, 10'h3FF); cyc();
    drive(1'b1, 10'h005, 16'h1234, 1'b1, 10'h3FF); cyc();
    drive(1'b0, '0, '0, 1'b1, 10'h005); cyc();
    chk("raw_w1", {obs_grant, obs_wen, obs_wdata}, {2'b00, 16'h1111});
    cyc();
    chk("raw_w2", {obs_grant, obs_wen, obs_wdata}, {2'b00, 16'h1234});
    cyc();
    chk("raw_grant", obs_grant, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0); cyc();
    chk("raw_rdata", {obs_rdv, obs_rdata}, {1'b1, 16'h1234});

    // Full buffer under continuous non-hazard reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(10'h100 + i), DATA_W'(16'hA000 + i), 1'b1, 10'h3FF);
      cyc();
    end
    drive(1'b1, 10'h104, 16'hA004, 1'b1, 10'h3FF);
    waited = 0; wen_seen = 0;
    cyc();
    chk("full_ready_low", obs_ready, 1'b0);
    while (!obs_ready && waited < 20) begin
      if (!obs_wen) wen_seen++;
      cyc();
      waited++;
    end
    chk("full_accepted", obs_ready, 1'b1);
    chk("full_freed_by_write", wen_seen, 1);
    drive(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cyc();
    chk("full_drained", obs_empty, 1'b1);

    // Reset mid-operation with three buffered writes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(10'h200 + i), DATA_W'(16'hBEE0 + i), 1'b1, 10'h3FF);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    rst = 1'b1; cyc();
    chk("midrst_cen", obs_cen, 1'b1);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    wen_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (!obs_wen) wen_seen++;
    end
    chk("midrst_no_writes", wen_seen, 0);
    chk("midrst_empty", obs_empty, 1'b1);

    // Random traffic on a small address range to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      hold = bus.comp_rd_req && !last_dr && !last_rst;
      bus.cfg_wr_valid = ($urandom_range(0, 1) == 1);
      bus.cfg_wr_addr  = ADDR_W'($urandom_range(0, 7));
      bus.cfg_wr_data  = DATA_W'($urandom);
      if (!hold) begin
        bus.comp_rd_req  = ($urandom_range(0, 9) < 6);
        bus.comp_rd_addr = ADDR_W'($urandom_range(0, 7));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
